ef_gpio8_in_cond: RTL and testbench
===================================

EF_GPIO8_IN_COND -- requirements
Module: ef_gpio8_in_cond

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the number of GPIO pins conditioned.
REQ-002 The module SHALL have parameter DB_CNT_W, default 8, the debounce counter width.
REQ-003 The module SHALL have one clock and an asynchronous active-high reset: port clk, input, 1, rising-edge clock.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port io_in, input, WIDTH, raw asynchronous pad inputs.
REQ-006 Port db_en, input, WIDTH, per-pin debounce enable.
REQ-007 Port db_limit, input, DB_CNT_W, shared debounce length in clk cycles.
REQ-008 Port data_in, output, WIDTH, conditioned pin levels that feed the DATAI register.
REQ-009 Port rise, output, WIDTH, one-cycle pulse on a conditioned 0->1 transition.
REQ-010 Port fall, output, WIDTH, one-cycle pulse on a conditioned 1->0 transition.

Function
REQ-011 Each pin SHALL pass through a two-flop synchronizer (ff1 then ff2); the ff2 output is called s below.
REQ-012 Each pin SHALL hold a state bit called stable (driven on data_in[i]) and a DB_CNT_W-bit counter cnt.
REQ-013 Bypass mode is db_en[i]=0 or db_limit=0: stable SHALL load s on every edge, so a change on io_in reaches data_in on the 3rd rising edge after it.
REQ-014 In debounce mode, when s==stable the pin SHALL clear cnt to 0.
REQ-015 In debounce mode, when s!=stable and cnt+1 >= db_limit, the pin SHALL load stable<=s and clear cnt to 0; otherwise it SHALL increment cnt.
REQ-016 A change therefore commits after exactly db_limit consecutive differing cycles of s; db_limit=1 behaves identically to bypass.
REQ-017 A glitch on s shorter than db_limit cycles SHALL clear cnt and SHALL NOT change data_in or pulse rise or fall.
REQ-018 Comparison SHALL use >=: if db_limit is lowered mid-count below cnt+1, the change SHALL commit on the next differing cycle, and cnt SHALL never wrap.
REQ-019 rise[i] and fall[i] SHALL be registered and asserted for exactly one cycle, in the same cycle data_in[i] first shows the new value.
REQ-020 rise[i] and fall[i] SHALL never be high simultaneously.
REQ-021 A toggle of db_en[i] mid-count SHALL take effect on the next edge; cnt SHALL be cleared while in bypass mode.
REQ-022 Pins SHALL be fully independent; simultaneous transitions on several pins SHALL produce simultaneous pulses.

Reset
REQ-023 While rst=1, ff1, ff2, stable, cnt, data_in, rise and fall SHALL all be 0, applied asynchronously.
REQ-024 After reset release with a pin held at 1, the pin SHALL commit normally per REQ-013 or REQ-015 and SHALL emit one rise pulse.
REQ-025 Asserting reset mid-debounce SHALL discard the count, with no pulse emitted.

Structure
REQ-026 Package ef_gpio8_pkg SHALL hold the WIDTH and DB_CNT_W defaults.
REQ-027 Package ef_gpio8_pkg SHALL hold the debounce-count type.
REQ-028 Sub-module ef_gpio8_pin_cond SHALL implement the synchronizer, debounce and edge logic for one pin.
REQ-029 The top SHALL instantiate ef_gpio8_pin_cond WIDTH times via generate.

Verification
REQ-030 Bypass latency: db_en=0x00, io_in 0x00->0xAB -> data_in=0xAB on the 3rd edge; rise=0xAB for 1 cycle; fall=0x00.
REQ-031 Debounce: db_en=0x01, db_limit=4, io_in[0] 0->1 held -> data_in[0]=1 exactly 4 cycles after s changes; a single rise[0] pulse.
REQ-032 Glitch rejection: db_limit=4, io_in[0] high for 3 cycles then low -> data_in[0] stays 0; rise and fall stay 0.
REQ-033 Falling edge: data_in=0xFF, io_in->0x5A with bypass -> data_in=0x5A; fall=0xA5 for 1 cycle; rise=0x00.
REQ-034 Limit change: db_limit=10, after 6 differing cycles set db_limit=3 -> commit on the next edge; cnt returns to 0.
REQ-035 Reset mid-count: db_limit=8, rst pulsed after 5 differing cycles -> all outputs 0 immediately; no pulse until a fresh 8-cycle count completes.

Source files
------------

// File: rtl/ef_gpio8_pkg.sv
// ef_gpio8_pkg: shared defaults and types for the GPIO input conditioner.
package ef_gpio8_pkg;
   localparam int WIDTH_DEF    = 8;
   localparam int DB_CNT_W_DEF = 8;
   typedef logic [DB_CNT_W_DEF-1:0] db_cnt_t;
endpackage

// File: rtl/ef_gpio8_pin_cond.sv
// ef_gpio8_pin_cond: one pin -- two-flop synchronizer, debounce counter and registered edge pulses.
module ef_gpio8_pin_cond
   import ef_gpio8_pkg::*;
#(
   parameter int DB_CNT_W = DB_CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                io_in,
   input  logic                db_en,
   input  logic [DB_CNT_W-1:0] db_limit,
   output logic                data_in,
   output logic                rise,
   output logic                fall
);
   logic                ff1, ff2, bypass, differ, hit, stable_nxt;
   logic [DB_CNT_W-1:0] cnt, cnt_nxt;
   logic [DB_CNT_W:0]   cnt_inc;
   // cnt_inc is one bit wider so the >= test never sees a wrapped count
   always_comb begin
      bypass     = !db_en || db_limit == '0;
      differ     = ff2 != data_in;
      cnt_inc    = {1'b0, cnt} + {{DB_CNT_W{1'b0}}, 1'b1};
      hit        = cnt_inc >= {1'b0, db_limit};
      stable_nxt = (bypass || (differ && hit)) ? ff2 : data_in;
      cnt_nxt    = (bypass || !differ || hit) ? '0 : cnt_inc[DB_CNT_W-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1     <= 1'b0;
         ff2     <= 1'b0;
         data_in <= 1'b0;
         cnt     <= '0;
         rise    <= 1'b0;
         fall    <= 1'b0;
      end else begin
         ff1     <= io_in;
         ff2     <= ff1;
         data_in <= stable_nxt;
         cnt     <= cnt_nxt;
         rise    <= stable_nxt & ~data_in;
         fall    <= ~stable_nxt & data_in;
      end
   end
endmodule

// File: rtl/ef_gpio8_in_cond.sv
// ef_gpio8_in_cond: conditions WIDTH raw pad inputs into synchronized, debounced levels with edge pulses.
module ef_gpio8_in_cond
   import ef_gpio8_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DB_CNT_W = DB_CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    io_in,
   input  logic [WIDTH-1:0]    db_en,
   input  logic [DB_CNT_W-1:0] db_limit,
   output logic [WIDTH-1:0]    data_in,
   output logic [WIDTH-1:0]    rise,
   output logic [WIDTH-1:0]    fall
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      ef_gpio8_pin_cond #(.DB_CNT_W(DB_CNT_W)) u_pin (
         .clk      (clk),
         .rst      (rst),
         .io_in    (io_in[i]),
         .db_en    (db_en[i]),
         .db_limit (db_limit),
         .data_in  (data_in[i]),
         .rise     (rise[i]),
         .fall     (fall[i])
      );
   end
endmodule

// File: tb/tb_ef_gpio8_in_cond.sv
// tb_ef_gpio8_in_cond: directed stimulus, per-cycle check against a behavioural model plus literal spot checks.
module tb_ef_gpio8_in_cond;
   import ef_gpio8_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] io_in = '0;
   logic [7:0] db_en = '0;
   db_cnt_t    db_limit = '0;
   logic [7:0] data_in, rise, fall;
   int n_cmp = 0;
   int n_bad = 0;

   ef_gpio8_in_cond dut (
      .clk(clk), .rst(rst), .io_in(io_in), .db_en(db_en), .db_limit(db_limit),
      .data_in(data_in), .rise(rise), .fall(fall)
   );

   always #5 clk = ~clk;

   // Model: s is io_in as seen two edges ago; a pin commits once s has
   // disagreed with the committed level for db_limit consecutive edges.
   logic [7:0] m_hist1, m_hist2, m_data, m_rise, m_fall, m_prev;
   int         m_run [8];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hist1 = '0; m_hist2 = '0; m_data = '0; m_rise = '0; m_fall = '0;
         for (int i = 0; i < 8; i++) m_run[i] = 0;
      end else begin
         m_prev = m_data;
         for (int i = 0; i < 8; i++) begin
            if (!db_en[i] || int'(db_limit) == 0) begin
               m_data[i] = m_hist2[i];
               m_run[i]  = 0;
            end else if (m_hist2[i] == m_prev[i]) m_run[i] = 0;
            else begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] >= int'(db_limit)) begin
                  m_data[i] = m_hist2[i];
                  m_run[i]  = 0;
               end
            end
         end
         m_rise  = m_data & ~m_prev;
         m_fall  = ~m_data & m_prev;
         m_hist2 = m_hist1;
         m_hist1 = io_in;
      end
   end

   always @(negedge clk) begin
      n_cmp++;
      if (data_in !== m_data || rise !== m_rise || fall !== m_fall || (rise & fall) !== 8'h00) begin
         n_bad++;
         $display("FAIL model t=%0t: data_in=%h rise=%h fall=%h required data_in=%h rise=%h fall=%h",
                  $time, data_in, rise, fall, m_data, m_rise, m_fall);
      end
   end

   task automatic expect8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      expect8("reset_data", data_in, 8'h00);
      expect8("reset_rise", rise, 8'h00);
      expect8("reset_fall", fall, 8'h00);
      tick(2);
      rst = 1'b0;
      tick(2);
      // bypass latency
      io_in = 8'hAB;
      tick(2);
      expect8("byp_data_edge2", data_in, 8'h00);
      tick(1);
      expect8("byp_data_edge3", data_in, 8'hAB);
      expect8("byp_rise", rise, 8'hAB);
      expect8("byp_fall", fall, 8'h00);
      tick(1);
      expect8("byp_rise_once", rise, 8'h00);
      // falling edges in bypass
      io_in = 8'hFF;
      tick(4);
      expect8("all_ones", data_in, 8'hFF);
      io_in = 8'h5A;
      tick(3);
      expect8("fall_data", data_in, 8'h5A);
      expect8("fall_fall", fall, 8'hA5);
      expect8("fall_rise", rise, 8'h00);
      // db_limit 0 and 1 both act as bypass
      db_en = 8'hFF;
      io_in = 8'h0F;
      tick(3);
      expect8("lim0_data", data_in, 8'h0F);
      db_limit = 8'd1;
      io_in = 8'hF0;
      tick(3);
      expect8("lim1_data", data_in, 8'hF0);
      // debounce of pin 0, limit 4
      db_en = 8'h00;
      io_in = 8'h00;
      tick(4);
      db_en = 8'h01;
      db_limit = 8'd4;
      io_in = 8'h01;
      tick(5);
      expect8("db_before", data_in, 8'h00);
      tick(1);
      expect8("db_commit", data_in, 8'h01);
      expect8("db_rise", rise, 8'h01);
      tick(1);
      expect8("db_rise_once", rise, 8'h00);
      io_in = 8'h00;
      tick(8);
      expect8("db_back_low", data_in, 8'h00);
      // glitch of 3 cycles rejected
      io_in = 8'h01;
      tick(3);
      io_in = 8'h00;
      tick(10);
      expect8("glitch_data", data_in, 8'h00);
      // lowering the limit mid-count commits on the next edge
      db_limit = 8'd10;
      io_in = 8'h01;
      tick(8);
      expect8("lim_chg_before", data_in, 8'h00);
      db_limit = 8'd3;
      tick(1);
      expect8("lim_chg_commit", data_in, 8'h01);
      expect8("lim_chg_rise", rise, 8'h01);
      io_in = 8'h00;
      tick(6);
      expect8("lim_chg_low", data_in, 8'h00);
      // reset mid-count discards it; a fresh 8-cycle count follows
      db_limit = 8'd8;
      io_in = 8'h01;
      tick(7);
      rst = 1'b1;
      #1;
      expect8("rst_mid_data", data_in, 8'h00);
      expect8("rst_mid_rise", rise, 8'h00);
      #1 rst = 1'b0;
      tick(9);
      expect8("rst_fresh_before", data_in, 8'h00);
      tick(1);
      expect8("rst_fresh_commit", data_in, 8'h01);
      expect8("rst_fresh_rise", rise, 8'h01);
      tick(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
